// File: rtl/fsm_arb_pkg.sv
// rtl/fsm_arb_pkg.sv - shared sizes, state type and one-hot helper for the round-robin arbiter
package fsm_arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/fsm_rr_arbiter_rr_pick.sv
// rtl/fsm_rr_arbiter_rr_pick.sv - combinational round-robin picker
// Scans last+1, last+2, ... modulo NUM_REQ and returns the first eligible agent.
module rr_pick
   import fsm_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [IDX_W-1:0]   last,
   output logic               any,
   output logic [IDX_W-1:0]   pick
);

   logic [IDX_W-1:0] w_idx;

   always_comb begin
      any   = 1'b0;
      pick  = '0;
      w_idx = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         w_idx = last + IDX_W'(i);
         if (!any && eligible[w_idx]) begin
            any  = 1'b1;
            pick = w_idx;
         end
      end
   end

endmodule

// File: rtl/fsm_rr_arbiter.sv
// rtl/fsm_rr_arbiter.sv - four-requester round-robin arbiter with grant-hold timeout
// A timed-out agent stays locked out until it drops its request.
module fsm_rr_arbiter
   import fsm_arb_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
)(
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic               gnt_valid,
   output logic [IDX_W-1:0]   gnt_id,
   output logic               timeout,
   output logic [NUM_REQ-1:0] lockout
);

   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

   state_t             r_state,     w_state;
   logic [NUM_REQ-1:0] r_gnt,       w_gnt;
   logic               r_gnt_valid;
   logic [IDX_W-1:0]   r_gnt_id,    w_gnt_id;
   logic               r_timeout,   w_timeout;
   logic [NUM_REQ-1:0] r_lockout,   w_lockout;
   logic [CNT_W-1:0]   r_hold_cnt,  w_hold_cnt;
   logic [IDX_W-1:0]   r_last,      w_last;

   logic               w_any;
   logic [IDX_W-1:0]   w_pick;

   rr_pick u_rr_pick (
      .eligible (req & ~r_lockout),
      .last     (r_last),
      .any      (w_any),
      .pick     (w_pick)
   );

   always_comb begin
      w_state    = r_state;
      w_gnt      = r_gnt;
      w_gnt_id   = r_gnt_id;
      w_timeout  = 1'b0;
      w_lockout  = r_lockout & req;
      w_hold_cnt = r_hold_cnt;
      w_last     = r_last;
      case (r_state)
         IDLE: begin
            w_gnt = '0;
            if (w_any) begin
               w_gnt      = onehot(w_pick);
               w_gnt_id   = w_pick;
               w_hold_cnt = HOLD_ONE;
               w_state    = GRANT;
            end
         end
         GRANT: begin
            if (!req[r_gnt_id]) begin
               w_gnt   = '0;
               w_last  = r_gnt_id;
               w_state = IDLE;
            end else if (MAX_HOLD != 0 && r_hold_cnt == HOLD_MAX) begin
               w_gnt               = '0;
               w_timeout           = 1'b1;
               w_lockout[r_gnt_id] = 1'b1;
               w_last              = r_gnt_id;
               w_state             = IDLE;
            end else if (MAX_HOLD == 0) begin
               w_hold_cnt = HOLD_ONE;
            end else if (r_hold_cnt != HOLD_MAX) begin
               w_hold_cnt = r_hold_cnt + HOLD_ONE;
            end
         end
         default: begin
            w_gnt   = '0;
            w_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= IDLE;
         r_gnt       <= '0;
         r_gnt_valid <= 1'b0;
         r_gnt_id    <= '0;
         r_timeout   <= 1'b0;
         r_lockout   <= '0;
         r_hold_cnt  <= '0;
         r_last      <= IDX_W'(NUM_REQ - 1);
      end else begin
         r_state     <= w_state;
         r_gnt       <= w_gnt;
         r_gnt_valid <= |w_gnt;
         r_gnt_id    <= w_gnt_id;
         r_timeout   <= w_timeout;
         r_lockout   <= w_lockout;
         r_hold_cnt  <= w_hold_cnt;
         r_last      <= w_last;
      end
   end

   assign gnt       = r_gnt;
   assign gnt_valid = r_gnt_valid;
   assign gnt_id    = r_gnt_id;
   assign timeout   = r_timeout;
   assign lockout   = r_lockout;

endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// tb/tb_fsm_rr_arbiter.sv - self-checking bench for fsm_rr_arbiter (MAX_HOLD 8 and 2 instances)
module tb_fsm_rr_arbiter;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       reset_a, reset_b;
   logic [3:0] req_a, req_b;
   logic [3:0] gnt_a, gnt_b, lockout_a, lockout_b;
   logic       gnt_valid_a, gnt_valid_b, timeout_a, timeout_b;
   logic [1:0] gnt_id_a, gnt_id_b;

   fsm_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut_a (
      .clock(clock), .reset(reset_a), .req(req_a), .gnt(gnt_a), .gnt_valid(gnt_valid_a),
      .gnt_id(gnt_id_a), .timeout(timeout_a), .lockout(lockout_a)
   );

   fsm_rr_arbiter #(.MAX_HOLD(2), .CNT_W(2)) dut_b (
      .clock(clock), .reset(reset_b), .req(req_b), .gnt(gnt_b), .gnt_valid(gnt_valid_b),
      .gnt_id(gnt_id_b), .timeout(timeout_b), .lockout(lockout_b)
   );

   logic [11:0] act_a, act_b;
   assign act_a = {gnt_a, gnt_valid_a, gnt_id_a, timeout_a, lockout_a};
   assign act_b = {gnt_b, gnt_valid_b, gnt_id_b, timeout_b, lockout_b};

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: one entry per instance (0 = MAX_HOLD 8, 1 = MAX_HOLD 2)
   int       mh[2] = '{8, 2};
   bit       m_busy[2];
   int       m_owner[2], m_held[2], m_last[2], m_gid[2];
   bit [3:0] m_lock[2];
   bit       m_to[2];

   task automatic model_step(input int k, input logic [3:0] r, input logic rs);
      bit [3:0] nl;
      int       p;
      if (rs) begin
         m_busy[k] = 0; m_owner[k] = 0; m_held[k] = 0; m_last[k] = 3;
         m_gid[k]  = 0; m_lock[k]  = 4'b0; m_to[k] = 0;
      end else begin
         nl      = m_lock[k] & r;
         m_to[k] = 0;
         if (m_busy[k]) begin
            if (!r[m_owner[k]]) begin
               m_busy[k] = 0;
               m_last[k] = m_owner[k];
            end else if (mh[k] != 0 && m_held[k] == mh[k]) begin
               m_busy[k]       = 0;
               m_to[k]         = 1;
               nl[m_owner[k]]  = 1'b1;
               m_last[k]       = m_owner[k];
            end else if (m_held[k] < mh[k]) begin
               m_held[k]++;
            end
         end else begin
            for (int off = 1; off <= 4; off++) begin
               p = (m_last[k] + off) % 4;
               if (r[p] && !m_lock[k][p]) begin
                  m_busy[k] = 1; m_owner[k] = p; m_gid[k] = p; m_held[k] = 1;
                  break;
               end
            end
         end
         m_lock[k] = nl;
      end
   endtask

   function automatic logic [11:0] exp_vec(input int k);
      logic [3:0] g;
      g = m_busy[k] ? 4'(1 << m_owner[k]) : 4'b0;
      return {g, |g, 2'(m_gid[k]), m_to[k], m_lock[k]};
   endfunction

   task automatic cycle(input logic [3:0] ra, input logic rsa, input logic [3:0] rb, input logic rsb);
      @(negedge clock);
      req_a = ra; reset_a = rsa;
      req_b = rb; reset_b = rsb;
      @(posedge clock);
      model_step(0, ra, rsa);
      model_step(1, rb, rsb);
      #1;
   endtask

   task automatic test_reset;
      cycle(4'hf, 1'b1, 4'hf, 1'b1);
      vectors++;
      if (act_a !== 12'h000) begin miscompares++; $display("FAIL reset_a: got %h expected %h", act_a, 12'h000); end
      vectors++;
      if (act_b !== 12'h000) begin miscompares++; $display("FAIL reset_b: got %h expected %h", act_b, 12'h000); end
      cycle(4'h0, 1'b0, 4'h0, 1'b0);
      vectors++;
      if (act_a !== 12'h000) begin miscompares++; $display("FAIL idle_a: got %h expected %h", act_a, 12'h000); end
      vectors++;
      if (act_b !== 12'h000) begin miscompares++; $display("FAIL idle_b: got %h expected %h", act_b, 12'h000); end
   endtask

   task automatic test_single_grant;
      cycle(4'h0, 1'b1, 4'h0, 1'b0);
      for (int e = 1; e <= 9; e++) cycle(4'h0, 1'b0, 4'h0, 1'b0);
      for (int e = 10; e <= 12; e++) begin
         cycle(4'b0001, 1'b0, 4'h0, 1'b0);
         vectors++;
         if ({gnt_a, gnt_valid_a, gnt_id_a, timeout_a} !== {4'b0001, 1'b1, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL single_hold e%0d: got gnt=%b v=%b id=%0d to=%b expected gnt=0001 v=1 id=0 to=0",
                     e, gnt_a, gnt_valid_a, gnt_id_a, timeout_a);
         end
      end
      cycle(4'b0000, 1'b0, 4'h0, 1'b0);
      vectors++;
      if ({gnt_a, gnt_valid_a, gnt_id_a, timeout_a} !== {4'b0000, 1'b0, 2'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL single_release: got gnt=%b v=%b id=%0d to=%b expected gnt=0000 v=0 id=0 to=0",
                  gnt_a, gnt_valid_a, gnt_id_a, timeout_a);
      end
      cycle(4'b0011, 1'b0, 4'h0, 1'b0);
      vectors++;
      if (gnt_a !== 4'b0010) begin
         miscompares++; $display("FAIL single_last0: got gnt=%b expected 0010", gnt_a);
      end
      cycle(4'b0000, 1'b0, 4'h0, 1'b0);
   endtask

   task automatic test_timeout_rotation;
      logic [3:0] eg[14] = '{4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
      logic       et[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [3:0] el[14] = '{4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h6, 4'h6, 4'h6, 4'he, 4'he, 4'he, 4'hf, 4'hf, 4'hf};
      cycle(4'h0, 1'b0, 4'h0, 1'b1);
      cycle(4'h0, 1'b0, 4'b0001, 1'b0);
      cycle(4'h0, 1'b0, 4'b0000, 1'b0);
      for (int i = 0; i < 14; i++) begin
         cycle(4'h0, 1'b0, 4'b1111, 1'b0);
         vectors++;
         if ({gnt_b, timeout_b, lockout_b} !== {eg[i], et[i], el[i]}) begin
            miscompares++;
            $display("FAIL rotation step%0d: got gnt=%b to=%b lock=%b expected gnt=%b to=%b lock=%b",
                     i, gnt_b, timeout_b, lockout_b, eg[i], et[i], el[i]);
         end
      end
      cycle(4'h0, 1'b0, 4'b0111, 1'b0);
      vectors++;
      if ({gnt_b, lockout_b} !== {4'b0000, 4'b0111}) begin
         miscompares++; $display("FAIL rotation_drop3: got gnt=%b lock=%b expected gnt=0000 lock=0111", gnt_b, lockout_b);
      end
      cycle(4'h0, 1'b0, 4'b1111, 1'b0);
      vectors++;
      if ({gnt_b, lockout_b} !== {4'b1000, 4'b0111}) begin
         miscompares++; $display("FAIL rotation_regrant3: got gnt=%b lock=%b expected gnt=1000 lock=0111", gnt_b, lockout_b);
      end
      cycle(4'h0, 1'b0, 4'b0000, 1'b0);
   endtask

   task automatic test_long_hold;
      logic [3:0] eg, el;
      logic       et;
      cycle(4'h0, 1'b1, 4'h0, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         cycle(4'b0100, 1'b0, 4'h0, 1'b0);
         eg = (i <= 8) ? 4'b0100 : 4'b0000;
         et = (i == 9);
         el = (i >= 9) ? 4'b0100 : 4'b0000;
         vectors++;
         if ({gnt_a, timeout_a, lockout_a} !== {eg, et, el}) begin
            miscompares++;
            $display("FAIL long_hold e%0d: got gnt=%b to=%b lock=%b expected gnt=%b to=%b lock=%b",
                     i, gnt_a, timeout_a, lockout_a, eg, et, el);
         end
      end
      cycle(4'b0000, 1'b0, 4'h0, 1'b0);
      vectors++;
      if ({gnt_a, lockout_a} !== 8'h00) begin
         miscompares++; $display("FAIL long_drop: got gnt=%b lock=%b expected gnt=0000 lock=0000", gnt_a, lockout_a);
      end
      cycle(4'b0100, 1'b0, 4'h0, 1'b0);
      vectors++;
      if ({gnt_a, gnt_id_a, lockout_a} !== {4'b0100, 2'd2, 4'b0000}) begin
         miscompares++;
         $display("FAIL long_regrant: got gnt=%b id=%0d lock=%b expected gnt=0100 id=2 lock=0000", gnt_a, gnt_id_a, lockout_a);
      end
      cycle(4'b0000, 1'b0, 4'h0, 1'b0);
   endtask

   task automatic test_rr_tie;
      cycle(4'h0, 1'b1, 4'h0, 1'b0);
      cycle(4'b0010, 1'b0, 4'h0, 1'b0);
      cycle(4'b0000, 1'b0, 4'h0, 1'b0);
      cycle(4'b1010, 1'b0, 4'h0, 1'b0);
      vectors++;
      if ({gnt_a, gnt_id_a} !== {4'b1000, 2'd3}) begin
         miscompares++; $display("FAIL tie_pick: got gnt=%b id=%0d expected gnt=1000 id=3", gnt_a, gnt_id_a);
      end
      cycle(4'b0010, 1'b0, 4'h0, 1'b0);
      vectors++;
      if ({gnt_a, timeout_a} !== {4'b0000, 1'b0}) begin
         miscompares++; $display("FAIL tie_gap: got gnt=%b to=%b expected gnt=0000 to=0", gnt_a, timeout_a);
      end
      cycle(4'b0010, 1'b0, 4'h0, 1'b0);
      vectors++;
      if ({gnt_a, gnt_id_a} !== {4'b0010, 2'd1}) begin
         miscompares++; $display("FAIL tie_next: got gnt=%b id=%0d expected gnt=0010 id=1", gnt_a, gnt_id_a);
      end
      cycle(4'b0000, 1'b0, 4'h0, 1'b0);
   endtask

   task automatic test_reset_mid_grant;
      cycle(4'h0, 1'b1, 4'h0, 1'b0);
      for (int i = 0; i < 9; i++) cycle(4'b0001, 1'b0, 4'h0, 1'b0);
      vectors++;
      if ({timeout_a, lockout_a} !== {1'b1, 4'b0001}) begin
         miscompares++; $display("FAIL midrst_lock: got to=%b lock=%b expected to=1 lock=0001", timeout_a, lockout_a);
      end
      cycle(4'b0101, 1'b0, 4'h0, 1'b0);
      vectors++;
      if (gnt_a !== 4'b0100) begin
         miscompares++; $display("FAIL midrst_grant2: got gnt=%b expected 0100", gnt_a);
      end
      cycle(4'b0101, 1'b0, 4'h0, 1'b0);
      cycle(4'b0101, 1'b0, 4'h0, 1'b0);
      cycle(4'b0101, 1'b1, 4'h0, 1'b0);
      vectors++;
      if (act_a !== 12'h000) begin
         miscompares++; $display("FAIL midrst_state: got %h expected %h", act_a, 12'h000);
      end
      cycle(4'b0101, 1'b0, 4'h0, 1'b0);
      vectors++;
      if ({gnt_a, gnt_id_a} !== {4'b0001, 2'd0}) begin
         miscompares++; $display("FAIL midrst_next: got gnt=%b id=%0d expected gnt=0001 id=0", gnt_a, gnt_id_a);
      end
      cycle(4'b0000, 1'b0, 4'h0, 1'b0);
   endtask

   task automatic test_random;
      logic [3:0] ra = 4'h0, rb = 4'h0;
      logic       sa, sb;
      for (int n = 0; n < 2000; n++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 5) == 0) ra[b] = ~ra[b];
            if ($urandom_range(0, 5) == 0) rb[b] = ~rb[b];
         end
         sa = ($urandom_range(0, 99) == 0);
         sb = ($urandom_range(0, 99) == 0);
         cycle(ra, sa, rb, sb);
         vectors++;
         if (act_a !== exp_vec(0)) begin
            miscompares++; $display("FAIL random_a n%0d: got %h expected %h", n, act_a, exp_vec(0));
         end
         vectors++;
         if (act_b !== exp_vec(1)) begin
            miscompares++; $display("FAIL random_b n%0d: got %h expected %h", n, act_b, exp_vec(1));
         end
      end
   endtask

   initial begin
      req_a = 4'h0; req_b = 4'h0; reset_a = 1'b1; reset_b = 1'b1;
      test_reset();
      test_single_grant();
      test_timeout_rotation();
      test_long_hold();
      test_rr_tie();
      test_reset_mid_grant();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
